// File: rtl/npu_layer_sequencer.sv
// npu_layer_sequencer: steps the PE array through a configured network,
// layer by layer, then streams the final layer's results out.
module npu_layer_sequencer #(
   parameter int MAX_LAYERS = 4,
   parameter int NEUR_W     = 5,
   parameter int NUM_PE     = 16,
   parameter int MAC_LAT    = 3,
   parameter int ACT_CYC    = 23
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [31:0]       cfg_data,
   input  logic              start,
   output logic [2:0]        pe_state,
   output logic [NUM_PE-1:0] pe_en,
   output logic              do_act,
   output logic              pe_oe,
   output logic [NEUR_W-1:0] out_idx,
   output logic [1:0]        layer_idx,
   output logic              busy,
   output logic              ready,
   output logic              cfg_err
);

   localparam int CW    = NEUR_W + 1;
   localparam int CNT_N = 2 * MAX_LAYERS;
   localparam logic [CW-1:0] PE_LIM  = CW'(NUM_PE - 1);
   localparam logic [CW-1:0] DRN_END = CW'(MAC_LAT - 1);
   localparam logic [CW-1:0] ACT_END = CW'(ACT_CYC - 1);

   localparam logic [2:0] P_IDLE    = 3'd0;
   localparam logic [2:0] P_MA      = 3'd2;
   localparam logic [2:0] P_MAB     = 3'd3;
   localparam logic [2:0] P_BIAS    = 3'd5;
   localparam logic [2:0] P_ACT     = 3'd6;
   localparam logic [2:0] P_ACT_CLR = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE, S_MA, S_BIAS, S_DRAIN, S_ACT, S_OUT, S_DONE
   } state_t;

   state_t            state;
   logic [NEUR_W-1:0] cnt [CNT_N];
   logic [1:0]        nl;
   logic [2:0]        widx;
   logic              configured;
   logic [CW-1:0]     ctr;
   logic [1:0]        layer;

   logic              last_layer;
   logic [2:0]        li;
   logic [NEUR_W-1:0] n_in_m1;
   logic [NEUR_W-1:0] n_out_m1;
   logic [NEUR_W-1:0] nxt_out_m1;
   logic              start_ok;
   logic              cfg_ok;
   logic [NEUR_W-1:0] cfg_cnt;
   logic              unused_cfg;

   assign li         = {1'b0, layer};
   assign last_layer = (layer == nl);
   assign n_in_m1    = cnt[li];
   assign n_out_m1   = cnt[li + 3'd1];
   assign nxt_out_m1 = cnt[li + 3'd2];
   assign start_ok   = start & ready;
   assign cfg_ok     = cfg_we & ~busy & ~start_ok;
   assign cfg_cnt    = cfg_data[NEUR_W-1:0];
   assign unused_cfg = ^cfg_data[31:NEUR_W];
   assign ready      = configured & ~cfg_err & ~busy;
   assign layer_idx  = layer;

   function automatic logic [NUM_PE-1:0] therm(
      input logic [NEUR_W-1:0] m1
   );
      logic [NUM_PE-1:0] t;
      for (int i = 0; i < NUM_PE; i++)
         t[i] = (CW'(i) <= {1'b0, m1});
      return t;
   endfunction

   // Word 0 restarts the sequence; counts, then the act flag, close it.
   always_ff @(posedge clk) begin
      if (rst) begin
         nl         <= '0;
         widx       <= '0;
         configured <= 1'b0;
         cfg_err    <= 1'b0;
         do_act     <= 1'b0;
         for (int i = 0; i < CNT_N; i++)
            cnt[i] <= '0;
      end else if (cfg_ok) begin
         if (configured || widx == 3'd0) begin
            nl         <= cfg_data[1:0];
            widx       <= 3'd1;
            configured <= 1'b0;
            cfg_err    <= 1'b0;
         end else if (widx == {1'b0, nl} + 3'd3) begin
            do_act     <= cfg_data[0];
            configured <= 1'b1;
            widx       <= 3'd0;
         end else begin
            cnt[widx - 3'd1] <= cfg_cnt;
            widx             <= widx + 3'd1;
            if (widx >= 3'd2 && {1'b0, cfg_cnt} > PE_LIM)
               cfg_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         ctr      <= '0;
         layer    <= '0;
         pe_state <= P_IDLE;
         pe_en    <= '0;
         pe_oe    <= 1'b0;
         out_idx  <= '0;
         busy     <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start_ok) begin
                  state    <= S_MA;
                  layer    <= '0;
                  ctr      <= '0;
                  busy     <= 1'b1;
                  pe_state <= P_MA;
                  pe_en    <= therm(cnt[1]);
               end
            end
            S_MA: begin
               if (ctr == {1'b0, n_in_m1}) begin
                  state    <= S_BIAS;
                  ctr      <= '0;
                  pe_state <= P_BIAS;
               end else begin
                  ctr <= ctr + 1'b1;
               end
            end
            S_BIAS: begin
               state    <= S_DRAIN;
               ctr      <= '0;
               pe_state <= P_IDLE;
            end
            S_DRAIN: begin
               if (ctr == DRN_END) begin
                  state    <= S_ACT;
                  ctr      <= '0;
                  pe_state <= last_layer ? P_ACT : P_ACT_CLR;
               end else begin
                  ctr <= ctr + 1'b1;
               end
            end
            S_ACT: begin
               if (ctr != ACT_END) begin
                  ctr <= ctr + 1'b1;
               end else if (!last_layer) begin
                  state    <= S_MA;
                  ctr      <= '0;
                  layer    <= layer + 2'd1;
                  pe_state <= P_MAB;
                  pe_en    <= therm(nxt_out_m1);
               end else begin
                  state    <= S_OUT;
                  ctr      <= '0;
                  pe_state <= P_IDLE;
                  pe_oe    <= 1'b1;
                  out_idx  <= '0;
               end
            end
            S_OUT: begin
               if (out_idx == n_out_m1) begin
                  state   <= S_DONE;
                  pe_oe   <= 1'b0;
                  pe_en   <= '0;
                  out_idx <= '0;
               end else begin
                  out_idx <= out_idx + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_npu_layer_sequencer.sv
// tb_npu_layer_sequencer: scoreboard bench for the layer sequencer;
// expected per-cycle outputs are queued and checked while busy.
module tb_npu_layer_sequencer;

   logic        clk = 1'b0;
   logic        rst, cfg_we, start;
   logic [31:0] cfg_data;
   logic [2:0]  pe_state;
   logic [15:0] pe_en;
   logic        do_act, pe_oe, busy, ready, cfg_err;
   logic [4:0]  out_idx;
   logic [1:0]  layer_idx;

   npu_layer_sequencer dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_data(cfg_data),
      .start(start), .pe_state(pe_state), .pe_en(pe_en),
      .do_act(do_act), .pe_oe(pe_oe), .out_idx(out_idx),
      .layer_idx(layer_idx), .busy(busy), .ready(ready),
      .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  st;
      logic [15:0] en;
      logic        oe;
      logic [4:0]  idx;
      logic [1:0]  lay;
      logic        act;
   } exp_t;

   exp_t        q[$];
   logic [31:0] cw[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          nl_m;
   int          c[8];
   logic        act_m;

   // Monitor: every busy cycle must match the next queued expectation.
   always @(negedge clk) begin
      if (busy === 1'b1) begin
         exp_t g, e;
         g = '{pe_state, pe_en, pe_oe, out_idx, layer_idx, do_act};
         vectors++;
         if (q.size() == 0) begin
            miscompares++;
            $display("FAIL trace_extra: got st=%0d busy=1, expected idle",
                     pe_state);
         end else begin
            e = q.pop_front();
            if (g !== e) begin
               miscompares++;
               $display("FAIL trace: got st=%0d en=%h oe=%0d idx=%0d lay=%0d act=%0d expected st=%0d en=%h oe=%0d idx=%0d lay=%0d act=%0d",
                        g.st, g.en, g.oe, g.idx, g.lay, g.act,
                        e.st, e.en, e.oe, e.idx, e.lay, e.act);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] got,
                        input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic send_cfg(input int from);
      for (int i = from; i < cw.size(); i++) begin
         cfg_we   = 1'b1;
         cfg_data = cw[i];
         tick();
      end
      cfg_we = 1'b0;
      nl_m = int'(cw[0][1:0]);
      for (int i = 0; i <= nl_m + 1; i++)
         c[i] = int'(cw[i+1][4:0]);
      act_m = cw[nl_m+3][0];
   endtask

   task automatic put(input exp_t e, inout int n, input int limit);
      if (n < limit) q.push_back(e);
      n++;
   endtask

   task automatic push_run(input int limit);
      exp_t        e;
      int          n;
      logic [16:0] m;
      n = 0;
      e.act = act_m;
      e.oe  = 1'b0;
      e.idx = '0;
      for (int l = 0; l <= nl_m; l++) begin
         m     = (17'd1 << (c[l+1] + 1)) - 17'd1;
         e.en  = m[15:0];
         e.lay = 2'(l);
         e.st  = (l == 0) ? 3'd2 : 3'd3;
         for (int k = 0; k <= c[l]; k++) put(e, n, limit);
         e.st = 3'd5;
         put(e, n, limit);
         e.st = 3'd0;
         for (int k = 0; k < 3; k++) put(e, n, limit);
         e.st = (l == nl_m) ? 3'd6 : 3'd7;
         for (int k = 0; k < 23; k++) put(e, n, limit);
      end
      e.st = 3'd0;
      e.oe = 1'b1;
      for (int i = 0; i <= c[nl_m+1]; i++) begin
         e.idx = 5'(i);
         put(e, n, limit);
      end
      e.en  = '0;
      e.oe  = 1'b0;
      e.idx = '0;
      put(e, n, limit);
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int i;
      for (i = 0; i < 3000; i++) begin
         tick();
         if (busy === 1'b0 && q.size() == 0) break;
      end
      if (i == 3000) begin
         miscompares++;
         $display("FAIL %s_timeout: got busy=%0d left=%0d expected 0 0",
                  nm, busy, q.size());
         q.delete();
      end
   endtask

   task automatic run(input string nm);
      push_run(1 << 20);
      do_start();
      wait_idle(nm);
      check({nm, "_busy_end"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic check_zero(input string nm);
      check({nm, "_pe_state"}, {29'd0, pe_state}, 32'd0);
      check({nm, "_pe_en"}, {16'd0, pe_en}, 32'd0);
      check({nm, "_misc"},
            {24'd0, do_act, pe_oe, busy, ready, cfg_err, layer_idx, 1'b0},
            32'd0);
      check({nm, "_out_idx"}, {27'd0, out_idx}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_data = '0; start = 1'b0;
      tick();
      tick();
      check_zero("reset");
      rst = 1'b0;
      tick();

      // T1: single layer 1->1, no activation
      cw = '{32'd0, 32'd0, 32'd0, 32'd0};
      send_cfg(0);
      check("t1_ready", {31'd0, ready}, 32'd1);
      check("t1_do_act", {31'd0, do_act}, 32'd0);
      run("t1");

      // T2: two layers 4->2->1 with activation; upper bits ignored
      cw = '{32'hFFFF_FFFD, 32'h0000_0023, 32'd1, 32'd0, 32'd1};
      send_cfg(0);
      check("t2_ready", {31'd0, ready}, 32'd1);
      check("t2_do_act", {31'd0, do_act}, 32'd1);
      check("t2_cfg_err", {31'd0, cfg_err}, 32'd0);
      run("t2");

      // T4: start and cfg_we during S_MA must not disturb the run
      push_run(1 << 20);
      do_start();
      tick();
      start = 1'b1; cfg_we = 1'b1; cfg_data = 32'd2;
      tick();
      start = 1'b0; cfg_we = 1'b0;
      wait_idle("t4");
      check("t4_ready_kept", {31'd0, ready}, 32'd1);

      // T3: n_out = 17 exceeds NUM_PE
      cw = '{32'd0, 32'd0, 32'd16, 32'd0};
      cfg_we = 1'b1; cfg_data = cw[0];
      tick();
      cfg_we = 1'b0;
      check("t3_restart_ready", {31'd0, ready}, 32'd0);
      send_cfg(1);
      check("t3_cfg_err", {31'd0, cfg_err}, 32'd1);
      check("t3_ready", {31'd0, ready}, 32'd0);
      do_start();
      tick();
      check("t3_pe_state", {29'd0, pe_state}, 32'd0);
      check("t3_busy", {31'd0, busy}, 32'd0);

      // T6: n_in = 32, also clears cfg_err via new word 0
      cw = '{32'd0, 32'd31, 32'd0, 32'd0};
      send_cfg(0);
      check("t6_cfg_err", {31'd0, cfg_err}, 32'd0);
      check("t6_ready", {31'd0, ready}, 32'd1);
      run("t6");

      // T5: reset in the 10th ACT_CLR cycle of layer 0
      cw = '{32'd1, 32'd3, 32'd1, 32'd0, 32'd1};
      send_cfg(0);
      push_run(18);
      do_start();
      repeat (17) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_zero("t5_rst");
      check("t5_queue", q.size(), 32'd0);
      q.delete();
      send_cfg(0);
      check("t5_ready", {31'd0, ready}, 32'd1);
      run("t5");

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
